spi_peripheral_responder: RTL and testbench

Peripheral-side SPI endpoint and counterpart to the SPI controller. It oversamples SCLK, CS_n and COPI in the system clock domain and captures one LENGTH_RECIEVED_P-bit word from the controller. It then waits PAUSE SCLK periods and shifts a LENGTH_SEND_P-bit response word back on CIPO. The local side uses a valid/ready load handshake and a received-word strobe.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_peripheral_responder.sv | 194 +++++++++++++++++++
 tb/tb_spi_peripheral_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI peripheral responder: frame defaults, FSM state codes,
// and a small helper for sizing counters.
package spi_pkg;

  localparam int unsigned DEFAULT_PAUSE             = 5;
  localparam int unsigned DEFAULT_LENGTH_SEND_P     = 16;
  localparam int unsigned DEFAULT_LENGTH_RECIEVED_P = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-bit input synchronizer with rise/fall detection on bit 0 (the SPI clock).
module spi_sync_edge #(
  parameter int unsigned     WIDTH     = 1,
  parameter int unsigned     STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_rise,
  output logic             o_fall
);

  logic [WIDTH-1:0] r_sync [STAGES];
  logic             r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= RESET_VAL;
      r_prev <= RESET_VAL[0];
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[STAGES-1][0];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q[0] & ~r_prev;
  assign o_fall = ~o_q[0] & r_prev;

endmodule

// File: rtl/spi_peripheral_responder.sv
// SPI mode-0 peripheral: receives a word on COPI, waits PAUSE SCLK periods, then shifts a
// response word out on CIPO. Response comes from a valid/ready holding register.
module spi_peripheral_responder
  import spi_pkg::*;
#(
  parameter int unsigned PAUSE             = DEFAULT_PAUSE,
  parameter int unsigned LENGTH_RECIEVED_P = DEFAULT_LENGTH_RECIEVED_P,
  parameter int unsigned LENGTH_SEND_P     = DEFAULT_LENGTH_SEND_P,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sclk,
  input  logic                         i_cs_n,
  input  logic                         i_copi,
  output logic                         o_cipo,
  output logic                         o_cipo_oe,
  input  logic [LENGTH_SEND_P-1:0]     i_tx_data,
  input  logic                         i_tx_valid,
  output logic                         o_tx_ready,
  output logic [LENGTH_RECIEVED_P-1:0] o_rx_data,
  output logic                         o_rx_valid,
  output logic                         o_frame_abort,
  output logic                         o_tx_underrun
);

  localparam int unsigned CNT_W = $clog2(max3(LENGTH_RECIEVED_P, LENGTH_SEND_P, PAUSE) + 1);
  localparam logic [CNT_W-1:0] RX_LAST    = CNT_W'(LENGTH_RECIEVED_P - 1);
  localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(LENGTH_SEND_P - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'((PAUSE == 0) ? 0 : PAUSE - 1);

  logic [2:0] w_sync;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_n;
  logic       w_copi;
  logic       w_cs_rise;
  logic       w_cs_fall;

  spi_sync_edge #(
    .WIDTH     (3),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (3'b010)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    ({i_copi, i_cs_n, i_sclk}),
    .o_q    (w_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  assign w_cs_n = w_sync[1];
  assign w_copi = w_sync[2];

  logic [2:0]                   r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_cs_prev;
  logic [LENGTH_RECIEVED_P-1:0] r_rx_shift;
  logic [LENGTH_RECIEVED_P-1:0] r_rx_data;
  logic [LENGTH_SEND_P-1:0]     r_tx_shift;
  logic [LENGTH_SEND_P-1:0]     r_hold;
  logic                         r_hold_full;
  logic                         r_rx_valid;
  logic                         r_abort;
  logic                         r_underrun;

  logic [2:0]                   w_state_nxt;
  logic [CNT_W-1:0]             w_cnt_nxt;
  logic                         w_enter_send;
  logic                         w_abort;
  logic                         w_rx_done;
  logic                         w_load;
  logic [LENGTH_RECIEVED_P-1:0] w_rx_next;

  assign w_cs_rise = w_cs_n & ~r_cs_prev;
  assign w_cs_fall = ~w_cs_n & r_cs_prev;
  assign w_load    = i_tx_valid & ~r_hold_full;
  assign w_rx_next = {r_rx_shift[LENGTH_RECIEVED_P-2:0], w_copi};

  // A chip-select rise takes priority over any SCLK edge seen in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_send = 1'b0;
    w_abort      = 1'b0;
    w_rx_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_RECV;
          w_cnt_nxt   = '0;
        end
      end
      ST_RECV: begin
        if (w_cs_rise) begin
          w_abort = 1'b1;
        end else if (w_sclk_rise) begin
          if (r_cnt == RX_LAST) begin
            w_rx_done = 1'b1;
            w_cnt_nxt = '0;
            if (PAUSE == 0) begin
              w_enter_send = 1'b1;
              w_state_nxt  = ST_SEND;
            end else begin
              w_state_nxt = ST_PAUSE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (w_cs_rise) begin
          w_abort = 1'b1;
        end else if (w_sclk_rise) begin
          if (r_cnt == PAUSE_LAST) begin
            w_enter_send = 1'b1;
            w_state_nxt  = ST_SEND;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_SEND: begin
        if (w_cs_rise) begin
          w_abort = 1'b1;
        end else if (w_sclk_fall) begin
          if (r_cnt == TX_LAST) begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (w_cs_n) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cs_prev   <= 1'b1;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_abort     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cs_prev  <= w_cs_n;
      r_rx_valid <= w_rx_done;
      r_abort    <= w_abort;
      r_underrun <= w_enter_send & ~r_hold_full;
      if (r_state == ST_RECV && w_sclk_rise && !w_cs_rise) r_rx_shift <= w_rx_next;
      if (w_rx_done) r_rx_data <= w_rx_next;
      if (w_enter_send) begin
        r_tx_shift <= r_hold_full ? r_hold : '1;
      end else if (r_state == ST_SEND && w_sclk_fall && !w_cs_rise) begin
        r_tx_shift <= r_tx_shift << 1;
      end
      // Consume before load: a load can only coincide with SEND entry when the register
      // was already empty, so the new word survives for the next frame.
      if (w_enter_send) r_hold_full <= 1'b0;
      if (w_load) begin
        r_hold      <= i_tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign o_cipo_oe     = (r_state == ST_SEND);
  assign o_cipo        = (r_state == ST_SEND) & r_tx_shift[LENGTH_SEND_P-1];
  assign o_tx_ready    = ~r_hold_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_frame_abort = r_abort;
  assign o_tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_peripheral_responder.sv
// Directed bench for spi_peripheral_responder: a mode-0 controller model drives frames,
// received words are checked from a scoreboard queue, response words after each frame.
module tb_spi_peripheral_responder;

  localparam int LR    = 8;
  localparam int LS    = 16;
  localparam int PAUSE = 5;
  localparam int TOTAL = LR + PAUSE + LS;
  localparam int HALF  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          cs_n;
  logic          copi;
  logic          cipo;
  logic          cipo_oe;
  logic [LS-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [LR-1:0] rx_data;
  logic          rx_valid;
  logic          frame_abort;
  logic          tx_underrun;

  spi_peripheral_responder #(
    .PAUSE             (PAUSE),
    .LENGTH_RECIEVED_P (LR),
    .LENGTH_SEND_P     (LS),
    .SYNC_STAGES       (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sclk        (sclk),
    .i_cs_n        (cs_n),
    .i_copi        (copi),
    .o_cipo        (cipo),
    .o_cipo_oe     (cipo_oe),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .o_frame_abort (frame_abort),
    .o_tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rxv   = 0;
  int n_abort = 0;
  int n_under = 0;

  logic [LR-1:0] rx_q [$];
  logic [LS-1:0] tx_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor; each rx_valid pops the oldest expected received word.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_abort) n_abort++;
      if (tx_underrun) n_under++;
      if (rx_valid) begin
        n_rxv++;
        if (rx_q.size() == 0) chk("rx_spurious", 32'(rx_data), 32'hFFFF_FFFF);
        else chk("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
    end
  end

  task automatic load_tx(input logic [LS-1:0] d);
    int t;
    t = 0;
    while (!tx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("load_ready", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Controller model: each period is a low half then a high half; cipo is sampled late in
  // the high half, covering the SEND bits starting at the period that enters SEND.
  task automatic do_frame(input logic [LR-1:0] word, input int abort_p,
                          output logic [LS-1:0] got, output int nbits);
    got   = '0;
    nbits = 0;
    cs_n  = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int p = 0; p < TOTAL; p++) begin
      if (p == abort_p) begin
        cs_n = 1'b1;
        return;
      end
      copi = (p < LR) ? word[LR-1-p] : 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (p >= LR + PAUSE - 1 && p < LR + PAUSE + LS - 1) begin
        got = {got[LS-2:0], cipo};
        nbits++;
      end
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_tx(input string tag, input logic [LS-1:0] got, input int nbits);
    logic [LS-1:0] e;
    e = (tx_q.size() != 0) ? tx_q.pop_front() : '0;
    chk({tag, "_bits"}, 32'(nbits), 32'(LS));
    chk(tag, 32'(got), 32'(e));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [LS-1:0] got;
  int            nbits;
  int            rxv0, ab0, un0, t;
  logic [LR-1:0] w;
  logic [LS-1:0] d;

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; copi = 1'b0; tx_data = '0; tx_valid = 1'b0;
    #23;
    chk("rst_cipo", 32'(cipo), 32'd0);
    chk("rst_cipo_oe", 32'(cipo_oe), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_strobes", {29'd0, rx_valid, frame_abort, tx_underrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Preloaded response
    load_tx(16'hA5C3);
    chk("tx_ready_after_load", 32'(tx_ready), 32'd0);
    rxv0 = n_rxv; ab0 = n_abort; un0 = n_under;
    rx_q.push_back(8'h3C); tx_q.push_back(16'hA5C3);
    do_frame(8'h3C, -1, got, nbits);
    check_tx("tx_a5c3", got, nbits);
    chk("tx_ready_after_send", 32'(tx_ready), 32'd1);
    chk("f1_rxv_count", 32'(n_rxv - rxv0), 32'd1);
    chk("f1_no_underrun", 32'(n_under - un0), 32'd0);
    chk("f1_no_abort", 32'(n_abort - ab0), 32'd0);

    // Underrun
    un0 = n_under;
    rx_q.push_back(8'h81); tx_q.push_back(16'hFFFF);
    do_frame(8'h81, -1, got, nbits);
    check_tx("tx_underrun_ones", got, nbits);
    chk("underrun_count", 32'(n_under - un0), 32'd1);
    chk("rx_data_81", 32'(rx_data), 32'h81);

    // Abort after 4 received bits
    rxv0 = n_rxv; ab0 = n_abort;
    do_frame(8'hC3, 4, got, nbits);
    repeat (10) @(negedge clk);
    chk("recv_abort_count", 32'(n_abort - ab0), 32'd1);
    chk("recv_abort_no_rxv", 32'(n_rxv - rxv0), 32'd0);
    chk("recv_abort_rx_kept", 32'(rx_data), 32'h81);
    load_tx(16'h6B2E);
    rx_q.push_back(8'h5A); tx_q.push_back(16'h6B2E);
    do_frame(8'h5A, -1, got, nbits);
    check_tx("tx_after_recv_abort", got, nbits);

    // Abort during the 7th SEND bit
    load_tx(16'hBEEF);
    ab0 = n_abort;
    rx_q.push_back(8'h77);
    do_frame(8'h77, LR + PAUSE - 1 + 6, got, nbits);
    t = 0;
    while (cipo_oe && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("send_abort_oe_drop", 32'(cipo_oe), 32'd0);
    chk("send_abort_latency_ok", 32'(t <= 4), 32'd1);
    chk("send_abort_partial_bits", 32'(nbits), 32'd6);
    chk("send_abort_partial", 32'(got), 32'(16'hBEEF >> 10));
    repeat (6) @(negedge clk);
    chk("send_abort_count", 32'(n_abort - ab0), 32'd1);
    chk("send_abort_ready", 32'(tx_ready), 32'd1);
    load_tx(16'h1234);
    rx_q.push_back(8'h99); tx_q.push_back(16'h1234);
    do_frame(8'h99, -1, got, nbits);
    check_tx("tx_1234", got, nbits);

    // Asynchronous reset in the middle of RECV
    load_tx(16'hDEAD);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      copi = p[0];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    #3 rst = 1'b1;
    #1;
    chk("async_rst_rx_data", 32'(rx_data), 32'd0);
    chk("async_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("async_rst_cipo_oe", 32'(cipo_oe), 32'd0);
    cs_n = 1'b1; copi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    load_tx(16'h0F0F);
    rx_q.push_back(8'hF0); tx_q.push_back(16'h0F0F);
    do_frame(8'hF0, -1, got, nbits);
    check_tx("tx_0f0f", got, nbits);

    // Back-to-back random frames, response loaded during PAUSE
    rxv0 = n_rxv; ab0 = n_abort; un0 = n_under;
    for (int k = 0; k < 10; k++) begin
      w = LR'($urandom);
      d = LS'($urandom);
      rx_q.push_back(w); tx_q.push_back(d);
      fork
        do_frame(w, -1, got, nbits);
        begin
          repeat (HALF + 2 * HALF * (LR + 1)) @(negedge clk);
          load_tx(d);
        end
      join
      check_tx("tx_b2b", got, nbits);
    end
    chk("b2b_rxv_count", 32'(n_rxv - rxv0), 32'd10);
    chk("b2b_no_abort", 32'(n_abort - ab0), 32'd0);
    chk("b2b_no_underrun", 32'(n_under - un0), 32'd0);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
